// File: rtl/motor_ctrl_pkg.sv
// Shared fixed-point constants and sample type for the Clarke / inverse Clarke path.
package motor_ctrl_pkg;
  localparam int W  = 32;
  localparam int KW = 16;

  typedef logic signed [W-1:0] sample_t;

  localparam logic signed [KW-1:0] K_SQRT3_2 = 16'sd28378;
  localparam sample_t SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam sample_t SAT_MIN = {1'b1, {(W-1){1'b0}}};
endpackage

// File: rtl/inv_clarke_if.sv
// Stream interface: alpha/beta in, a/b/c out, both with valid/ready.
interface inv_clarke_if;
  import motor_ctrl_pkg::*;

  logic    in_valid;
  logic    in_ready;
  sample_t alpha;
  sample_t beta;
  logic    out_valid;
  logic    out_ready;
  sample_t va;
  sample_t vb;
  sample_t vc;
  logic    sat;

  modport master (
    output in_valid, alpha, beta, out_ready,
    input  in_ready, out_valid, va, vb, vc, sat
  );

  modport slave (
    input  in_valid, alpha, beta, out_ready,
    output in_ready, out_valid, va, vb, vc, sat
  );
endinterface

// File: rtl/sat_add.sv
// (W+2)-bit signed add/subtract, saturated to W bits with an overflow flag.
module sat_add
  import motor_ctrl_pkg::*;
(
  input  logic signed [W+1:0] a,
  input  logic signed [W+1:0] b,
  input  logic                sub,
  output sample_t             y,
  output logic                ovf
);
  logic signed [W+1:0] s;

  always_comb begin
    s   = sub ? (a - b) : (a + b);
    // Result fits W bits only when the top three bits agree.
    ovf = (s[W+1:W-1] != 3'b000) && (s[W+1:W-1] != 3'b111);
    y   = ovf ? (s[W+1] ? SAT_MIN : SAT_MAX) : s[W-1:0];
  end
endmodule

// File: rtl/inv_clarke.sv
// Inverse Clarke transform, 3-stage pipeline with a single global stall.
module inv_clarke
  import motor_ctrl_pkg::*;
(
  input logic         clk,
  input logic         rst,
  inv_clarke_if.slave bus
);
  localparam logic signed [W+KW-1:0] RND = (W+KW)'(1) <<< (KW-2);

  logic    en;
  logic [3:1] vld_q, vld_d;
  sample_t alpha1_q, alpha1_d, beta1_q, beta1_d;
  sample_t alpha2_q, alpha2_d, h2_q, h2_d, pr2_q, pr2_d;
  sample_t va_q, va_d, vb_q, vb_d, vc_q, vc_d;
  logic    sat_q, sat_d;

  logic signed [W+KW-1:0] p;
  logic signed [W+1:0]    neg_h, pr_x;
  sample_t                sb, sc;
  logic                   ovf_b, ovf_c;

  // Only a held output word can stall the pipe; empty stages never block.
  assign en           = ~(vld_q[3] & ~bus.out_ready);
  assign bus.in_ready = en;

  assign neg_h = -((W+2)'(h2_q));
  assign pr_x  = (W+2)'(pr2_q);

  sat_add u_sat_b (.a(neg_h), .b(pr_x), .sub(1'b0), .y(sb), .ovf(ovf_b));
  sat_add u_sat_c (.a(neg_h), .b(pr_x), .sub(1'b1), .y(sc), .ovf(ovf_c));

  always_comb begin
    vld_d    = vld_q;
    alpha1_d = alpha1_q;
    beta1_d  = beta1_q;
    alpha2_d = alpha2_q;
    h2_d     = h2_q;
    pr2_d    = pr2_q;
    va_d     = va_q;
    vb_d     = vb_q;
    vc_d     = vc_q;
    sat_d    = sat_q;
    p        = beta1_q * K_SQRT3_2;
    if (en) begin
      vld_d    = {vld_q[2:1], bus.in_valid};
      alpha1_d = bus.alpha;
      beta1_d  = bus.beta;
      alpha2_d = alpha1_q;
      h2_d     = alpha1_q >>> 1;
      // Round half-up; the scaled product always fits back into W bits.
      pr2_d    = sample_t'((p + RND) >>> (KW-1));
      va_d     = alpha2_q;
      vb_d     = sb;
      vc_d     = sc;
      sat_d    = ovf_b | ovf_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      alpha1_q <= '0;
      beta1_q  <= '0;
      alpha2_q <= '0;
      h2_q     <= '0;
      pr2_q    <= '0;
      va_q     <= '0;
      vb_q     <= '0;
      vc_q     <= '0;
      sat_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      alpha1_q <= alpha1_d;
      beta1_q  <= beta1_d;
      alpha2_q <= alpha2_d;
      h2_q     <= h2_d;
      pr2_q    <= pr2_d;
      va_q     <= va_d;
      vb_q     <= vb_d;
      vc_q     <= vc_d;
      sat_q    <= sat_d;
    end
  end

  assign bus.out_valid = vld_q[3];
  assign bus.va        = va_q;
  assign bus.vb        = vb_q;
  assign bus.vc        = vc_q;
  assign bus.sat       = sat_q;
endmodule

// File: tb/tb_inv_clarke.sv
// Directed and randomized checks of inv_clarke: latency, stall, reset, rounding, saturation.
module tb_inv_clarke;
  import motor_ctrl_pkg::*;

  typedef logic [96:0] rec_t;  // {va, vb, vc, sat}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inv_clarke_if bus();
  inv_clarke dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int   n_tests = 0;
  int   n_fail  = 0;
  rec_t got_q[$];
  rec_t exp_q[$];

  function automatic rec_t model(input logic signed [31:0] a, input logic signed [31:0] b);
    longint p, pr, h, sb, sc;
    logic [31:0] yb, yc;
    logic s1, s2;
    p  = longint'(b) * 28378;
    pr = (p + 16384) >>> 15;
    h  = longint'(a) >>> 1;
    sb = pr - h;
    sc = -h - pr;
    s1 = 1'b1; s2 = 1'b1;
    if (sb > 64'sd2147483647) yb = 32'h7FFFFFFF;
    else if (sb < -64'sd2147483648) yb = 32'h80000000;
    else begin yb = sb[31:0]; s1 = 1'b0; end
    if (sc > 64'sd2147483647) yc = 32'h7FFFFFFF;
    else if (sc < -64'sd2147483648) yc = 32'h80000000;
    else begin yc = sc[31:0]; s2 = 1'b0; end
    return {a, yb, yc, s1 | s2};
  endfunction

  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready)
      got_q.push_back({bus.va, bus.vb, bus.vc, bus.sat});
    if (!rst && bus.in_valid && bus.in_ready)
      exp_q.push_back(model(bus.alpha, bus.beta));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ea, input logic [31:0] eb,
                            input logic [31:0] ec, input logic es);
    bus.in_valid = 1'b1; bus.alpha = a; bus.beta = b;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk({tag, " early"}, 128'(bus.out_valid), 128'(0));
    tick();
    chk({tag, " valid"}, 128'(bus.out_valid), 128'(1));
    chk({tag, " data"}, 128'({bus.va, bus.vb, bus.vc, bus.sat}), 128'({ea, eb, ec, es}));
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, stall_cnt, r;
    logic accept, prev_stall;
    rec_t snap, g;
    longint ident;

    bus.in_valid = 1'b0; bus.alpha = '0; bus.beta = '0; bus.out_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    chk("rst out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst outputs", 128'({bus.va, bus.vb, bus.vc, bus.sat}), 128'(0));
    rst = 1'b0;
    tick();
    chk("in_ready after rst", 128'(bus.in_ready), 128'(1));

    send_check("alpha only", 32'h00010000, 32'h0, 32'h00010000, 32'hFFFF8000, 32'hFFFF8000, 1'b0);
    send_check("beta only", 32'h0, 32'h00010000, 32'h0, 32'h0000DDB4, 32'hFFFF224C, 1'b0);
    send_check("sat hi", 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hD1260001, 1'b1);
    send_check("sat lo", 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h2EDA0001, 1'b1);
    send_check("odd neg", 32'h00000003, 32'hFFFF0000, 32'h00000003, 32'hFFFF224B, 32'h0000DDB3, 1'b0);

    // 8-word stream with out_ready low for four cycles
    got_q.delete(); exp_q.delete();
    idx = 0; stall_cnt = 0; prev_stall = 1'b0; snap = '0;
    for (int c = 0; c < 30; c++) begin
      bus.out_ready = !(c >= 5 && c < 9);
      bus.in_valid  = (idx < 8);
      bus.alpha     = 32'((idx + 1) * 256);
      bus.beta      = '0;
      #1;
      chk("stream in_ready", 128'(bus.in_ready), 128'(!(bus.out_valid && !bus.out_ready)));
      if (prev_stall)
        chk("stall stable", 128'({bus.va, bus.vb, bus.vc, bus.sat}), 128'(snap));
      prev_stall = bus.out_valid && !bus.out_ready;
      if (prev_stall) stall_cnt++;
      snap   = {bus.va, bus.vb, bus.vc, bus.sat};
      accept = bus.in_valid && bus.in_ready;
      tick();
      if (accept) idx++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk("stall cycles", 128'(stall_cnt), 128'(4));
    chk("stream count", 128'(got_q.size()), 128'(8));
    for (int k = 1; k <= 8 && k <= got_q.size(); k++)
      chk($sformatf("stream word %0d", k), 128'(got_q[k-1]),
          128'({32'(k * 256), 32'(-k * 128), 32'(-k * 128), 1'b0}));

    // Reset while the pipe is full and stalled
    got_q.delete(); exp_q.delete();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.alpha = 32'h00001000; bus.beta = 32'h00002000;
    for (int c = 0; c < 5; c++) tick();
    chk("full out_valid", 128'(bus.out_valid), 128'(1));
    chk("full in_ready", 128'(bus.in_ready), 128'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.in_valid = 1'b0;
    chk("midrst out_valid", 128'(bus.out_valid), 128'(0));
    chk("midrst outputs", 128'({bus.va, bus.vb, bus.vc, bus.sat}), 128'(0));
    chk("midrst in_ready", 128'(bus.in_ready), 128'(1));
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("no stale word", 128'(got_q.size()), 128'(0));

    // Random traffic with random backpressure against the model
    got_q.delete(); exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 8);
      r = $urandom_range(0, 7);
      bus.alpha     = (r == 0) ? 32'h80000000 : (r == 1) ? 32'h7FFFFFFF : $urandom;
      r = $urandom_range(0, 7);
      bus.beta      = (r == 0) ? 32'h80000000 : (r == 1) ? 32'h7FFFFFFF : $urandom;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && got_q.size() != exp_q.size(); c++) tick();
    chk("rand count", 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      g = got_q[i];
      chk($sformatf("rand word %0d", i), 128'(g), 128'(exp_q[i]));
      if (!g[0]) begin
        ident = longint'(signed'(g[64:33])) + longint'(signed'(g[32:1]))
              + 2 * (longint'(signed'(g[96:65])) >>> 1);
        chk($sformatf("rand sum %0d", i), 128'(ident), 128'(0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
